// File: rtl/io_sched_pkg.sv
// io_sched_pkg: shared types and helpers for the I/O write-posting scheduler.
// Holds the FSM state encoding, slot-index width helper and default timeout.
package io_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PWRUN,
      NPDRAIN,
      NPRUN,
      NPDONE
   } state_t;

   localparam int TMO_CYC_DEF = 255;

   // Slot index width for a queue of the given depth, never below one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pw_queue_ctr.sv
// pw_queue_ctr: write/read slot pointers and occupancy of the posted-write queue.
// Simultaneous push and pop leave the count unchanged while both pointers move.
module pw_queue_ctr
   import io_sched_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enq_i,
   input  logic                     deq_i,
   output logic [ptr_w(DEPTH)-1:0]  wptr_o,
   output logic [ptr_w(DEPTH)-1:0]  rptr_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Advance pointers with wrap at DEPTH and track occupancy.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (enq_i) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
      if (deq_i) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
      unique case ({enq_i, deq_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign wptr_o  = wptr_q;
   assign rptr_o  = rptr_q;
   assign full_o  = (cnt_q == FULL);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/io_sched.sv
// io_sched: posts CPU I/O writes into a small queue and orders slow-bus cycles.
// Define IOSCHED_TIMEOUT_EN to add the IOACK timeout and sticky IOTimeout port.
module io_sched
   import io_sched_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic                     FCLK,
   input  logic                     nRESET,
   input  logic                     BACT,
   input  logic                     IOPWCS,
   input  logic                     IONPCS,
   input  logic                     IOACK,
   output logic                     IOPWReady,
   output logic                     IONPReady,
`ifdef IOSCHED_TIMEOUT_EN
   output logic                     IOTimeout,
`endif
   output logic                     IOREQ,
   output logic                     IOPW,
   output logic                     PWLoad,
   output logic [ptr_w(DEPTH)-1:0]  PWSlot,
   output logic [ptr_w(DEPTH)-1:0]  IOSlot
);

   localparam int PW = ptr_w(DEPTH);

   state_t        state_q, state_d;
   logic          acc_q, acc_d;
   logic          abort_q, abort_d;
   logic          live_q;
   logic          enq, deq, ack, tmo;
   logic          full, empty;
   logic [PW-1:0] wptr, rptr;

   pw_queue_ctr #(.DEPTH(DEPTH)) u_q (
      .clk_i   (FCLK),
      .rst_ni  (nRESET),
      .enq_i   (enq),
      .deq_i   (deq),
      .wptr_o  (wptr),
      .rptr_o  (rptr),
      .full_o  (full),
      .empty_o (empty)
   );

   // A full queue may still accept when the head completes this cycle.
   assign enq = live_q && BACT && IOPWCS && !acc_q
              && (!full || deq)
              && (state_q != NPRUN) && (state_q != NPDONE);
   assign ack = IOREQ && (IOACK || tmo);
   assign deq = (state_q == PWRUN) && ack;

   assign PWLoad    = enq;
   assign PWSlot    = wptr;
   assign IOPWReady = acc_q;

`ifdef IOSCHED_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;
   logic       tmo_q;

   assign tmo       = IOREQ && !IOACK && (tcnt_q == 8'(TMO_CYC - 1));
   assign IOTimeout = tmo_q;

   // Count stalled request cycles; restart on any completion.
   always_comb begin
      tcnt_d = '0;
      if (IOREQ && !IOACK && !tmo) tcnt_d = tcnt_q + 8'd1;
   end

   // Timeout counter and sticky flag.
   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tmo_q  <= tmo_q | tmo;
      end
   end
`else
   logic tmo_unused;
   assign tmo        = 1'b0;
   assign tmo_unused = (TMO_CYC != 0);
`endif

   // Accept flag holds until the bus cycle ends; abort latches a dropped NP cycle.
   always_comb begin
      acc_d   = acc_q;
      if (!BACT)    acc_d = 1'b0;
      else if (enq) acc_d = 1'b1;
      abort_d = (state_q == NPRUN) && (abort_q || !BACT);
   end

   // Bookkeeping registers; live_q keeps enqueue off until after reset.
   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         acc_q   <= 1'b0;
         abort_q <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         abort_q <= abort_d;
         live_q  <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state: queued writes always drain ahead of a non-posted access.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (BACT && IONPCS) state_d = empty ? NPRUN : NPDRAIN;
            else if (!empty)    state_d = PWRUN;
         end
         PWRUN:   if (ack) state_d = IDLE;
         NPDRAIN: begin
            if (!BACT)      state_d = IDLE;
            else if (empty) state_d = NPRUN;
            else            state_d = PWRUN;
         end
         NPRUN: begin
            if (ack) state_d = (BACT && !abort_q) ? NPDONE : IDLE;
         end
         NPDONE:  if (!BACT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slow-bus and handshake outputs decoded from state.
   always_comb begin
      IOREQ     = 1'b0;
      IOPW      = 1'b0;
      IONPReady = 1'b0;
      IOSlot    = '0;
      unique case (state_q)
         PWRUN: begin
            IOREQ  = 1'b1;
            IOPW   = 1'b1;
            IOSlot = rptr;
         end
         NPRUN:   IOREQ     = 1'b1;
         NPDONE:  IONPReady = 1'b1;
         default: IOREQ     = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_io_sched.sv
// tb_io_sched: scenario tests for io_sched with a transfer-order scoreboard.
// Build with IOSCHED_TIMEOUT_EN to add the timeout scenario on a second DUT.
module tb_io_sched;

   localparam int PW = 1;

   typedef struct packed {
      logic          pw;
      logic [PW-1:0] slot;
   } iss_t;

   logic          FCLK = 1'b0;
   logic          nRESET = 1'b0;
   logic          BACT = 1'b0;
   logic          IOPWCS = 1'b0;
   logic          IONPCS = 1'b0;
   logic          IOACK = 1'b0;
   logic          IOPWReady, IONPReady, IOREQ, IOPW, PWLoad;
   logic [PW-1:0] PWSlot, IOSlot;

   int   n_tests = 0;
   int   n_fail  = 0;
   iss_t exp_q[$];
   iss_t e;
   logic prev_req = 1'b0;

   always #5 FCLK = ~FCLK;

   io_sched #(.DEPTH(2)) dut (
      .FCLK      (FCLK),
      .nRESET    (nRESET),
      .BACT      (BACT),
      .IOPWCS    (IOPWCS),
      .IONPCS    (IONPCS),
      .IOACK     (IOACK),
      .IOPWReady (IOPWReady),
      .IONPReady (IONPReady),
`ifdef IOSCHED_TIMEOUT_EN
      .IOTimeout (),
`endif
      .IOREQ     (IOREQ),
      .IOPW      (IOPW),
      .PWLoad    (PWLoad),
      .PWSlot    (PWSlot),
      .IOSlot    (IOSlot)
   );

`ifdef IOSCHED_TIMEOUT_EN
   logic          t_IOPWReady, t_IONPReady, t_IOREQ, t_IOPW, t_PWLoad;
   logic          t_IOTimeout;
   logic [PW-1:0] t_PWSlot, t_IOSlot;

   io_sched #(.DEPTH(2), .TMO_CYC(4)) dut_t (
      .FCLK      (FCLK),
      .nRESET    (nRESET),
      .BACT      (BACT),
      .IOPWCS    (IOPWCS),
      .IONPCS    (IONPCS),
      .IOACK     (1'b0),
      .IOPWReady (t_IOPWReady),
      .IONPReady (t_IONPReady),
      .IOTimeout (t_IOTimeout),
      .IOREQ     (t_IOREQ),
      .IOPW      (t_IOPW),
      .PWLoad    (t_PWLoad),
      .PWSlot    (t_PWSlot),
      .IOSlot    (t_IOSlot)
   );
`endif

   // Scoreboard consumer: each new slow-bus transfer must match the oldest expectation.
   always @(negedge FCLK) begin
      if (!nRESET) begin
         prev_req = 1'b0;
      end else begin
         if (IOREQ && !prev_req) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_order: got pw=%0b slot=%0d, required no transfer",
                        IOPW, IOSlot);
            end else begin
               e = exp_q.pop_front();
               if ({IOPW, IOSlot} !== e) begin
                  n_fail++;
                  $display("FAIL issue_order: got pw=%0b slot=%0d, required pw=%0b slot=%0d",
                           IOPW, IOSlot, e.pw, e.slot);
               end
            end
         end
         prev_req = IOREQ;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge FCLK);
      #1;
   endtask

   task automatic do_reset();
      BACT = 0; IOPWCS = 0; IONPCS = 0; IOACK = 0;
      nRESET = 0;
      exp_q.delete();
      cyc(2);
      nRESET = 1;
      cyc(2);
   endtask

   task automatic post_write(input logic [PW-1:0] slot);
      exp_q.push_back({1'b1, slot});
      BACT = 1; IOPWCS = 1;
      cyc(1);
      BACT = 0; IOPWCS = 0;
      cyc(1);
   endtask

   task automatic serve(input int n, output int done);
      done = 0;
      for (int k = 0; k < n; k++) begin
         for (int w = 0; w < 20 && !IOREQ; w++) cyc(1);
         if (IOREQ) begin
            IOACK = 1;
            cyc(1);
            IOACK = 0;
            done++;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if ({IOREQ, IOPW, PWLoad, IOPWReady, IONPReady, PWSlot, IOSlot} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required all zero",
                  {IOREQ, IOPW, PWLoad, IOPWReady, IONPReady, PWSlot, IOSlot});
      end
      do_reset();
      n_tests++;
      if (IOREQ !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: IOREQ=%b, required 0", IOREQ);
      end
   endtask

   task automatic test_single_pw();
      do_reset();
      exp_q.push_back({1'b1, 1'b0});
      BACT = 1; IOPWCS = 1;
      #1;
      n_tests++;
      if ({PWLoad, PWSlot, IOPWReady} !== 3'b100) begin
         n_fail++;
         $display("FAIL single_load: PWLoad/PWSlot/IOPWReady=%b, required 100",
                  {PWLoad, PWSlot, IOPWReady});
      end
      cyc(1);
      n_tests++;
      if ({IOPWReady, PWLoad} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_ready: IOPWReady/PWLoad=%b, required 10",
                  {IOPWReady, PWLoad});
      end
      BACT = 0; IOPWCS = 0;
      cyc(1);
      n_tests++;
      if ({IOREQ, IOPW, IOSlot} !== 3'b110 || dut.u_q.cnt_q !== 2'd1) begin
         n_fail++;
         $display("FAIL single_issue: IOREQ/IOPW/IOSlot=%b cnt=%0d, required 110 cnt=1",
                  {IOREQ, IOPW, IOSlot}, dut.u_q.cnt_q);
      end
      IOACK = 1;
      cyc(1);
      IOACK = 0;
      n_tests++;
      if (IOREQ !== 1'b0 || dut.u_q.cnt_q !== 2'd0) begin
         n_fail++;
         $display("FAIL single_done: IOREQ=%b cnt=%0d, required 0 cnt=0",
                  IOREQ, dut.u_q.cnt_q);
      end
      IOACK = 1;
      cyc(1);
      IOACK = 0;
      cyc(2);
      n_tests++;
      if (IOREQ !== 1'b0 || dut.u_q.cnt_q !== 2'd0 || dut.u_q.rptr_q !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_ack: IOREQ=%b cnt=%0d rptr=%0d, required 0 cnt=0 rptr=1",
                  IOREQ, dut.u_q.cnt_q, dut.u_q.rptr_q);
      end
   endtask

   task automatic test_full_queue();
      int done;
      do_reset();
      post_write(1'b0);
      post_write(1'b1);
      exp_q.push_back({1'b1, 1'b0});
      BACT = 1; IOPWCS = 1;
      #1;
      n_tests++;
      if (PWLoad !== 1'b0) begin
         n_fail++;
         $display("FAIL full_block: PWLoad=%b, required 0", PWLoad);
      end
      cyc(3);
      n_tests++;
      if (IOPWReady !== 1'b0 || IOREQ !== 1'b1) begin
         n_fail++;
         $display("FAIL full_wait: IOPWReady=%b IOREQ=%b, required 0 1",
                  IOPWReady, IOREQ);
      end
      IOACK = 1;
      #1;
      n_tests++;
      if ({PWLoad, PWSlot} !== 2'b10) begin
         n_fail++;
         $display("FAIL full_reload: PWLoad/PWSlot=%b, required 10", {PWLoad, PWSlot});
      end
      cyc(1);
      IOACK = 0;
      n_tests++;
      if (IOPWReady !== 1'b1 || dut.u_q.cnt_q !== 2'd2) begin
         n_fail++;
         $display("FAIL full_accept: IOPWReady=%b cnt=%0d, required 1 cnt=2",
                  IOPWReady, dut.u_q.cnt_q);
      end
      BACT = 0; IOPWCS = 0;
      serve(2, done);
      n_tests++;
      if (done !== 2 || dut.u_q.cnt_q !== 2'd0) begin
         n_fail++;
         $display("FAIL full_drain: served=%0d cnt=%0d, required 2 cnt=0",
                  done, dut.u_q.cnt_q);
      end
   endtask

   task automatic test_np_ordered();
      int done;
      do_reset();
      post_write(1'b0);
      post_write(1'b1);
      exp_q.push_back({1'b0, 1'b0});
      BACT = 1; IONPCS = 1;
      cyc(2);
      serve(2, done);
      for (int w = 0; w < 20 && !IOREQ; w++) cyc(1);
      n_tests++;
      if (done !== 2 || {IOREQ, IOPW, IONPReady} !== 3'b100) begin
         n_fail++;
         $display("FAIL np_issue: served=%0d IOREQ/IOPW/IONPReady=%b, required 2 100",
                  done, {IOREQ, IOPW, IONPReady});
      end
      IOACK = 1;
      cyc(1);
      IOACK = 0;
      cyc(2);
      n_tests++;
      if ({IONPReady, IOREQ} !== 2'b10) begin
         n_fail++;
         $display("FAIL np_ready: IONPReady/IOREQ=%b, required 10", {IONPReady, IOREQ});
      end
      BACT = 0; IONPCS = 0;
      cyc(1);
      n_tests++;
      if (IONPReady !== 1'b0) begin
         n_fail++;
         $display("FAIL np_release: IONPReady=%b, required 0", IONPReady);
      end
   endtask

   task automatic test_enq_with_ack();
      int done;
      do_reset();
      post_write(1'b0);
      exp_q.push_back({1'b1, 1'b1});
      BACT = 1; IOPWCS = 1; IOACK = 1;
      #1;
      n_tests++;
      if ({PWLoad, PWSlot} !== 2'b11) begin
         n_fail++;
         $display("FAIL same_load: PWLoad/PWSlot=%b, required 11", {PWLoad, PWSlot});
      end
      cyc(1);
      IOACK = 0;
      n_tests++;
      if (dut.u_q.cnt_q !== 2'd1 || dut.u_q.wptr_q !== 1'b0 || dut.u_q.rptr_q !== 1'b1) begin
         n_fail++;
         $display("FAIL same_cycle: cnt=%0d wptr=%0d rptr=%0d, required cnt=1 wptr=0 rptr=1",
                  dut.u_q.cnt_q, dut.u_q.wptr_q, dut.u_q.rptr_q);
      end
      BACT = 0; IOPWCS = 0;
      serve(1, done);
      n_tests++;
      if (done !== 1 || dut.u_q.cnt_q !== 2'd0) begin
         n_fail++;
         $display("FAIL same_drain: served=%0d cnt=%0d, required 1 cnt=0",
                  done, dut.u_q.cnt_q);
      end
   endtask

   task automatic test_reset_midrun();
      bit seen;
      do_reset();
      post_write(1'b0);
      post_write(1'b1);
      #2;
      nRESET = 0;
      #1;
      n_tests++;
      if ({IOREQ, IOPW, PWLoad, IOPWReady, IONPReady, PWSlot, IOSlot} !== '0
          || dut.u_q.cnt_q !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_async: outputs=%b cnt=%0d, required zero cnt=0",
                  {IOREQ, IOPW, PWLoad, IOPWReady, IONPReady, PWSlot, IOSlot},
                  dut.u_q.cnt_q);
      end
      exp_q.delete();
      cyc(1);
      nRESET = 1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         if (IOREQ) seen = 1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_discard: IOREQ seen=%b, required 0", seen);
      end
   endtask

`ifdef IOSCHED_TIMEOUT_EN
   task automatic test_timeout();
      int hi;
      int done;
      do_reset();
      n_tests++;
      if (t_IOTimeout !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_reset: IOTimeout=%b, required 0", t_IOTimeout);
      end
      post_write(1'b0);
      for (int w = 0; w < 20 && !t_IOREQ; w++) cyc(1);
      hi = 0;
      while (t_IOREQ && hi < 20) begin
         hi++;
         cyc(1);
      end
      n_tests++;
      if (hi !== 4 || t_IOTimeout !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_fire: IOREQ cycles=%0d IOTimeout=%b, required 4 1",
                  hi, t_IOTimeout);
      end
      cyc(3);
      n_tests++;
      if (t_IOTimeout !== 1'b1 || t_IOREQ !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_sticky: IOTimeout=%b IOREQ=%b, required 1 0",
                  t_IOTimeout, t_IOREQ);
      end
      serve(1, done);
      n_tests++;
      if (done !== 1) begin
         n_fail++;
         $display("FAIL tmo_main: served=%0d, required 1", done);
      end
   endtask
`endif

   task automatic test_scoreboard_empty();
      cyc(4);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d transfers outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_pw();
      test_full_queue();
      test_np_ordered();
      test_enq_with_ack();
      test_reset_midrun();
`ifdef IOSCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_scoreboard_empty();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_sched.md
IO_SCHED -- requirements
Module: io_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 2, posted-write queue entries (1, 2 or 4).
REQ-002 SHALL have parameter TMO_CYC, default 255, IOACK timeout in FCLK cycles (8-bit, used only with IOSCHED_TIMEOUT_EN).
REQ-003 SHALL have FCLK input 1, sole clock; all state SHALL update on posedge FCLK.
REQ-004 SHALL have nRESET input 1, active-low asynchronous reset.
REQ-005 SHALL have BACT input 1, CPU bus cycle active.
REQ-006 SHALL have IOPWCS input 1, access to a postable I/O write region.
REQ-007 SHALL have IONPCS input 1, non-postable I/O access (reads, ordered writes).
REQ-008 SHALL have IOACK input 1, one-cycle slow-bus completion pulse, pre-synchronized to FCLK.
REQ-009 SHALL have IOPWReady output 1, current posted write has been enqueued.
REQ-010 SHALL have IONPReady output 1, current non-posted access has completed.
REQ-011 SHALL have IOREQ output 1, slow-bus request, a level held until completion.
REQ-012 SHALL have IOPW output 1, qualifies IOREQ: 1 means posted write from the queue, 0 means non-posted.
REQ-013 SHALL have PWLoad output 1, one-cycle pulse telling the data latch to capture the CPU address and data.
REQ-014 SHALL have PWSlot and IOSlot outputs, each log2(DEPTH) wide (min 1): the write slot index and the issuing slot index.
REQ-015 SHALL have IOTimeout output 1, sticky; present only with IOSCHED_TIMEOUT_EN.

Function
REQ-016 SHALL run a state machine with states IDLE, PWRUN, NPDRAIN, NPRUN and NPDONE.
REQ-017 SHALL enqueue a posted write as follows:
- Condition: first cycle with BACT && IOPWCS && count<DEPTH && !acc.
- Actions: pulse PWLoad with PWSlot=wptr; increment wptr (wrapping at DEPTH) and count; set acc.
REQ-018 SHALL clear acc only in a cycle with BACT=0, so each bus cycle enqueues at most once.
REQ-019 SHALL drive IOPWReady=acc, registered; when the queue is full, IOPWReady SHALL stay 0 until a slot frees and the enqueue occurs.
REQ-020 SHALL transition IDLE->PWRUN when count>0: IOREQ=1, IOPW=1, IOSlot=rptr.
REQ-021 SHALL, in PWRUN on IOACK: drop IOREQ, increment rptr (wrapping) and decrement count, then return to IDLE for at least one cycle before the next issue.
REQ-022 SHALL resolve a simultaneous enqueue and IOACK by leaving count unchanged while both pointers advance.
REQ-023 SHALL handle BACT && IONPCS in IDLE as follows:
- count>0: go to NPDRAIN; the queue drains first (ordering).
- count=0: go to NPRUN.
REQ-024 SHALL return from NPDRAIN to NPRUN only when count=0 and no IOREQ is pending.
REQ-025 SHALL, in NPRUN: IOREQ=1, IOPW=0; on IOACK go to NPDONE.
REQ-026 SHALL, in NPDONE: IONPReady=1 until BACT=0, then go to IDLE; IONPReady SHALL be 0 in all other states.
REQ-027 SHALL, if BACT drops in NPDRAIN or NPRUN (aborted cycle): finish the current slow-bus transfer, then go to IDLE without asserting IONPReady.
REQ-028 SHALL give pending posted writes priority over a new non-posted request; posted writes SHALL NOT be enqueued while the state is NPRUN or NPDONE.
REQ-029 SHALL ignore IOACK when IOREQ=0.

Reset
REQ-030 SHALL, on nRESET low, immediately set:
- state=IDLE;
- count, wptr, rptr, acc and the timeout counter = 0;
- IOREQ, IOPW, PWLoad, IOPWReady, IONPReady, IOTimeout = 0; PWSlot and IOSlot = 0.
REQ-031 SHALL discard queued writes when reset occurs mid-transfer; IOREQ SHALL drop asynchronously.

Configuration
REQ-032 SHALL, when IOSCHED_TIMEOUT_EN is defined:
- Count the cycles IOREQ=1 without IOACK.
- On reaching TMO_CYC: treat it as IOACK, set IOTimeout=1 until reset, and restart the counter.
REQ-033 SHALL, when IOSCHED_TIMEOUT_EN is undefined, have no IOTimeout port or counter and wait indefinitely for IOACK.

Structure
REQ-034 SHALL place the state enum, the DEPTH-derived pointer width function and the default TMO_CYC in shared package io_sched_pkg.
REQ-035 SHALL implement the pointers and count in one sub-module, pw_queue_ctr; the state machine SHALL remain in io_sched.

Verification
REQ-036 SHALL cover: one posted write, queue empty:
- Response: PWLoad pulse with PWSlot=0; IOPWReady=1 on the next cycle; IOREQ=1 with IOPW=1 and IOSlot=0.
- After IOACK: count=0.
REQ-037 SHALL cover: three back-to-back posted writes, DEPTH=2, IOACK withheld:
- Response: the third write holds IOPWReady=0.
- IOACK, then IOPWReady=1 on the following cycle; PWSlot=0 for the third write.
REQ-038 SHALL cover: non-posted read with 2 queued writes:
- Response: two PW transfers (IOSlot 0, then 1), then IOREQ with IOPW=0.
- IOACK, then IONPReady=1 until BACT=0.
REQ-039 SHALL cover: enqueue in the same cycle as IOACK at count=1 -> count stays 1; wptr and rptr both advance.
REQ-040 SHALL cover: nRESET pulsed during PWRUN with count=2 -> all outputs 0 within the same cycle; after release, no IOREQ.
REQ-041 SHALL cover, with IOSCHED_TIMEOUT_EN and TMO_CYC=4: IOREQ with no IOACK -> IOREQ drops after 4 cycles, IOTimeout=1 sticky.
